plot_sink: RTL and testbench

PLOT_SINK -- requirements
Module: plot_sink

---
 rtl/plot_sink_pkg.sv | 16 +
 rtl/pixel_fifo.sv | 36 +++
 rtl/plot_sink.sv | 84 ++++++++
 tb/tb_plot_sink.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/plot_sink_pkg.sv
// plot_sink_pkg: shared game screen geometry, background colour, sink FSM encoding and pixel entry type
package plot_sink_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] BG_COLOUR = 3'b111;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: DEPTH-entry FIFO of {x,y,colour}; ports clk, resetn, push/din, pop/dout, full, empty
module pixel_fifo import plot_sink_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [$bits(pixel_t)-1:0] din,
  output logic [$bits(pixel_t)-1:0] dout,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [$bits(pixel_t)-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/plot_sink.sv
// plot_sink: queues game pixels (dropping off-screen ones) and plots them or a full background clear to the VGA adapter; ports in_* handshake, clear_req/clear_busy, vga_* plot outputs, drop_count
module plot_sink import plot_sink_pkg::*; #(
  parameter int         DEPTH     = 8,
  parameter int         SCREEN_W  = plot_sink_pkg::SCREEN_W,
  parameter int         SCREEN_H  = plot_sink_pkg::SCREEN_H,
  parameter logic [2:0] BG_COLOUR = plot_sink_pkg::BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] drop_count
);
  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [7:0] drop_q, drop_d;
  logic       plot_q, plot_d;
  pixel_t     out_q, out_d;
  pixel_t     head;
  logic       full, empty, fire, on_screen, push, pop, row_end, last;
  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (pixel_t'{in_x, in_y[6:0], in_colour}),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );
  assign in_ready = !full && !busy_q;
  always_comb begin
    fire      = in_valid && in_ready;
    on_screen = int'(in_x) < SCREEN_W && int'(in_y) < SCREEN_H;
    push      = fire && on_screen;
    pop       = !empty && state_q != ST_CLEAR;
    row_end   = int'(cx_q) == SCREEN_W - 1;
    last      = state_q == ST_CLEAR && row_end && int'(cy_q) == SCREEN_H - 1;
    busy_d    = busy_q ? !last : clear_req;
    drop_d    = drop_q + 8'(fire && !on_screen && drop_q != 8'hff);
    state_d   = state_q == ST_CLEAR ? (last ? ST_IDLE : ST_CLEAR) :
                busy_q && empty ? ST_CLEAR : empty ? ST_IDLE : ST_DRAIN;
    cx_d      = state_q != ST_CLEAR || row_end ? 8'd0 : cx_q + 8'd1;
    cy_d      = state_q != ST_CLEAR ? 7'd0 : row_end ? cy_q + 7'd1 : cy_q;
    plot_d    = pop || state_q == ST_CLEAR;
    out_d     = pop ? head : state_q == ST_CLEAR ? pixel_t'{cx_q, cy_q, BG_COLOUR} : out_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      drop_q  <= '0;
      plot_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      drop_q  <= drop_d;
      plot_q  <= plot_d;
      out_q   <= out_d;
    end
  end
  assign clear_busy = busy_q;
  assign drop_count = drop_q;
  assign vga_plot   = plot_q;
  assign vga_x      = out_q.x;
  assign vga_y      = out_q.y;
  assign vga_colour = out_q.colour;
endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: randomized and directed checks of plot_sink against a queue-based reference model
`timescale 1ns/1ps
module tb_plot_sink;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       clear_req = 1'b0;
  logic       clear_busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [7:0] drop_count;
  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];
  logic [18:0] e;
  int drops = 0;
  bit busy_m = 0;
  int clr_seen = 0;
  always #5 clk = ~clk;
  plot_sink dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .drop_count (drop_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      drops = 0;
      busy_m = 0;
      check("rst_plot", 32'(vga_plot), 0);
      check("rst_busy", 32'(clear_busy), 0);
    end else begin
      if (vga_plot) begin
        check("plot_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("plot", 32'({vga_x, vga_y, vga_colour}), 32'(e[17:0]));
          if (e[18]) begin
            clr_seen++;
            if (clr_seen == 19200) busy_m = 0;
          end
        end
      end
      check("busy", 32'(clear_busy), 32'(busy_m));
      check("drops", 32'(drop_count), 32'(drops));
      if (busy_m) check("ready_while_busy", 32'(in_ready), 0);
      if (in_valid && in_ready) begin
        if (in_x < 8'd160 && in_y < 8'd120) exp_q.push_back({1'b0, in_x, in_y[6:0], in_colour});
        else if (drops < 255) drops++;
      end
      if (clear_req && !busy_m) begin
        busy_m = 1;
        clr_seen = 0;
        for (int yy = 0; yy < 120; yy++)
          for (int xx = 0; xx < 160; xx++)
            exp_q.push_back({1'b1, 8'(xx), 7'(yy), 3'b111});
      end
    end
  end
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input int budget);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_colour = c;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'(acc), 1);
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    in_valid = 1'b0;
    clear_req = 1'b0;
    #1;
    check("rst_vga_plot", 32'(vga_plot), 0);
    check("rst_vga_x", 32'(vga_x), 0);
    check("rst_vga_y", 32'(vga_y), 0);
    check("rst_vga_colour", 32'(vga_colour), 0);
    check("rst_clear_busy", 32'(clear_busy), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 1);
  endtask
  task automatic wait_drained(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 0);
  endtask
  initial begin
    int plots;
    do_reset();
    @(posedge clk);
    #1;
    send(8'd10, 8'd20, 3'b100, 1);
    @(negedge clk);
    check("lat_n1_plot", 32'(vga_plot), 0);
    @(negedge clk);
    check("lat_n2_plot", 32'(vga_plot), 1);
    check("lat_n2_x", 32'(vga_x), 10);
    check("lat_n2_y", 32'(vga_y), 20);
    check("lat_n2_colour", 32'(vga_colour), 3'b100);
    wait_drained("first_drained");
    do_reset();
    @(posedge clk);
    #1;
    send(8'd160, 8'd0, 3'b001, 1);
    send(8'd0, 8'd120, 3'b010, 1);
    repeat (5) @(negedge clk);
    check("drop_two", 32'(drop_count), 2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++)
      send(8'($urandom_range(160, 255)), 8'($urandom_range(0, 255)), 3'($urandom), 1);
    repeat (3) @(negedge clk);
    check("drop_sat", 32'(drop_count), 255);
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_x = 8'($urandom_range(0, 180));
      in_y = 8'($urandom_range(0, 135));
      in_colour = 3'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drained("random_drained");
    for (int i = 0; i < 50; i++) send(8'(i * 3), 8'(i + 7), 3'(i), 1);
    wait_drained("stream_drained");
    do_reset();
    @(posedge clk);
    #1;
    send(8'd1, 8'd2, 3'd1, 1);
    send(8'd3, 8'd4, 3'd2, 1);
    clear_req = 1'b1;
    send(8'd5, 8'd6, 3'd3, 1);
    clear_req = 1'b0;
    for (int i = 0; i < 9; i++) send(8'(i * 17), 8'(i + 100), 3'(7 - i), 25000);
    wait_drained("clear_drained");
    check("clear_plot_count", 32'(clr_seen), 19200);
    check("clear_busy_end", 32'(clear_busy), 0);
    @(posedge clk);
    #1;
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    for (int i = 0; i < 6000 && clr_seen < 5000; i++) @(posedge clk);
    check("clear_reached_5000", 32'(clr_seen >= 5000), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("midclr_rst_plot", 32'(vga_plot), 0);
    check("midclr_rst_busy", 32'(clear_busy), 0);
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    @(negedge clk);
    check("midclr_ready", 32'(in_ready), 1);
    plots = 0;
    repeat (50) begin
      @(negedge clk);
      plots += int'(vga_plot);
    end
    check("midclr_no_plots", 32'(plots), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
